ddfs_wave_monitor: RTL and testbench

//  Receive-side monitor for the DDFS-to-VGA-DAC sample stream (q_VGA, blank_n).

---
 rtl/ddfs_pkg.sv | 20 ++
 rtl/ddfs_xing_det.sv | 57 +++++
 rtl/ddfs_wave_monitor.sv | 176 +++++++++++++++++
 tb/tb_ddfs_wave_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// Shared DDFS definitions: sample width, crossing-threshold defaults and the
// wave-monitor FSM state encoding.
package ddfs_pkg;

    // Width of the q_VGA sample bus driven by the DDFS
    localparam int DATA_W = 10;

    // Mid-scale crossing threshold and the hysteresis half-band around it
    localparam int MID_DEFAULT  = 512;
    localparam int HYST_DEFAULT = 16;

    // Wave-monitor measurement sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } mon_state_e;

endpackage : ddfs_pkg

// File: rtl/ddfs_xing_det.sv
// Hysteresis rising-crossing detector for the DDFS sample stream.
// The detector arms when a valid sample falls to or below MID-HYST and reports
// one registered crossing pulse when a later valid sample reaches MID+HYST.
// Blanked samples are ignored entirely: the arm state is held, no pulse fires.
module ddfs_xing_det #(
    parameter int DATA_W = ddfs_pkg::DATA_W,
    parameter int MID    = ddfs_pkg::MID_DEFAULT,
    parameter int HYST   = ddfs_pkg::HYST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              blank_n,
    output logic              xing
);

    // Thresholds are inclusive: a sample exactly on a threshold counts as beyond it
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);

    logic lo_armed_q, lo_armed_d;
    logic xing_q, xing_d;

    // Next arm state and crossing decision from the current (qualified) sample
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        lo_armed_d = lo_armed_q;
        xing_d     = 1'b0;
        if (blank_n) begin
            if (lo_armed_q && (sample >= HI_TH)) begin
                xing_d     = 1'b1;
                lo_armed_d = 1'b0;
            end else if (sample <= LO_TH) begin
                lo_armed_d = 1'b1;
            end
        end
    end

    // Arm flag and registered crossing pulse
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so rst_n is only looked at on the
        // clock edge and is therefore not in the sensitivity list.
        if (!rst_n) begin
            lo_armed_q <= 1'b0;
            xing_q     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            lo_armed_q <= lo_armed_d;
            xing_q     <= xing_d;
        end
    end

    assign xing = xing_q;

endmodule : ddfs_xing_det

// File: rtl/ddfs_wave_monitor.sv
// Receive-side monitor for the DDFS-to-DAC sample stream. Measures the
// waveform period in clk cycles, averaged over NUM_PERIODS rising crossings,
// together with the minimum and maximum valid sample over the same window.
// Results are registered on entry to DONE so that period/vmin/vmax change only
// together with the meas_valid pulse and hold between pulses.
module ddfs_wave_monitor
    import ddfs_pkg::*;
#(
    parameter int DATA_W      = ddfs_pkg::DATA_W,
    parameter int CNT_W       = 24,
    parameter int NUM_PERIODS = 4,   // must be a power of two, >= 1
    parameter int MID         = ddfs_pkg::MID_DEFAULT,
    parameter int HYST        = ddfs_pkg::HYST_DEFAULT,
    parameter int TIMEOUT     = 2**24 - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              blank_n,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              meas_valid,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vmax
);

    // Averaging is a plain right shift, hence the power-of-two period count
    localparam int                LOG2_NP   = $clog2(NUM_PERIODS);
    localparam int                NC_W      = $clog2(NUM_PERIODS + 1);
    localparam logic [NC_W-1:0]   NC_LAST   = NC_W'(NUM_PERIODS);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

    mon_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NC_W-1:0]   ncross_q, ncross_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DATA_W-1:0] vmin_q, vmin_d;
    logic [DATA_W-1:0] vmax_q, vmax_d;

    logic xing;
    logic timeout_hit;

    ddfs_xing_det #(
        .DATA_W (DATA_W),
        .MID    (MID),
        .HYST   (HYST)
    ) u_xing_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (sample),
        .blank_n (blank_n),
        .xing    (xing)
    );

    // The counter stops at TIMEOUT because the sequencer leaves SYNC/MEASURE
    // on that very cycle, so it can never wrap.
    assign timeout_hit = (cnt_q == TIMEOUT_C);

    // Sequencer next state, counters, min/max accumulators and result capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ncross_d = ncross_q;
        min_d    = min_q;
        max_d    = max_q;
        period_d = period_q;
        vmin_d   = vmin_q;
        vmax_d   = vmax_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SYNC;
                    cnt_d    = '0;
                    ncross_d = '0;
                    min_d    = '1;
                    max_d    = '0;
                end
            end

            SYNC: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (xing) begin
                    // The first crossing opens the window; accumulators are
                    // seeded from the sample present on this cycle.
                    state_d  = MEASURE;
                    cnt_d    = CNT_W'(1);
                    ncross_d = '0;
                    if (blank_n) begin
                        min_d = sample;
                        max_d = sample;
                    end else begin
                        min_d = '1;
                        max_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            MEASURE: begin
                if (timeout_hit) begin
                    // Partial results are dropped; published outputs stay put
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (blank_n) begin
                        if (sample < min_q) min_d = sample;
                        if (sample > max_q) max_d = sample;
                    end
                    if (xing) begin
                        ncross_d = ncross_q + NC_W'(1);
                        if (ncross_d == NC_LAST) begin
                            state_d  = DONE;
                            period_d = cnt_d >> LOG2_NP;
                            vmin_d   = min_d;
                            vmax_d   = max_d;
                        end
                    end
                end
            end

            DONE: begin
                // start is not looked at here; continuous alone decides re-arm
                if (continuous) begin
                    state_d  = SYNC;
                    cnt_d    = '0;
                    ncross_d = '0;
                    min_d    = '1;
                    max_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, counter, accumulator and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ncross_q <= '0;
            min_q    <= '1;
            max_q    <= '0;
            period_q <= '0;
            vmin_q   <= '1;
            vmax_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ncross_q <= ncross_d;
            min_q    <= min_d;
            max_q    <= max_d;
            period_q <= period_d;
            vmin_q   <= vmin_d;
            vmax_q   <= vmax_d;
        end
    end

    assign busy        = (state_q == SYNC) || (state_q == MEASURE);
    assign meas_valid  = (state_q == DONE);
    assign err_timeout = busy && timeout_hit;
    assign period      = period_q;
    assign vmin        = vmin_q;
    assign vmax        = vmax_q;

endmodule : ddfs_wave_monitor

// File: tb/tb_ddfs_wave_monitor.sv
// Self-checking bench for ddfs_wave_monitor (NUM_PERIODS=4, TIMEOUT=1000).
// A free-running generator produces square, ramp or constant waveforms with
// randomized parameters; expected period/min/max come from the waveform
// definition itself.
module tb_ddfs_wave_monitor;

    localparam int DW      = 10;
    localparam int CW      = 24;
    localparam int NP      = 4;
    localparam int TMO     = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] sample;
    logic          blank_n;
    logic          start;
    logic          continuous;
    logic          busy;
    logic          meas_valid;
    logic          err_timeout;
    logic [CW-1:0] period;
    logic [DW-1:0] vmin;
    logic [DW-1:0] vmax;

    ddfs_wave_monitor #(
        .DATA_W      (DW),
        .CNT_W       (CW),
        .NUM_PERIODS (NP),
        .MID         (512),
        .HYST        (16),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample      (sample),
        .blank_n     (blank_n),
        .start       (start),
        .continuous  (continuous),
        .busy        (busy),
        .meas_valid  (meas_valid),
        .err_timeout (err_timeout),
        .period      (period),
        .vmin        (vmin),
        .vmax        (vmax)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waveform generator: 0 = constant, 1 = square, 2 = ramp
    int mode      = 0;
    int const_lvl = 0;
    int half      = 50;
    int lo_lvl    = 0;
    int hi_lvl    = 1023;
    int step      = 8;
    int rlen      = 128;
    bit blank_en  = 1'b0;
    int ph        = 0;

    initial begin
        sample  = '0;
        blank_n = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: begin
                    ph      = (ph + 1) % (2 * half);
                    sample  = (ph < half) ? 10'(hi_lvl) : 10'(lo_lvl);
                    blank_n = !(blank_en && ph >= half + 5 && ph < half + 15);
                    if (!blank_n) sample = 10'd1023;   // glitch hidden by blanking
                end
                2: begin
                    ph      = (ph + 1) % rlen;
                    sample  = 10'(ph * step);
                    blank_n = 1'b1;
                end
                default: begin
                    sample  = 10'(const_lvl);
                    blank_n = 1'b1;
                end
            endcase
        end
    end

    // Result monitor
    typedef struct { int per; int mn; int mx; } meas_t;
    meas_t mq[$];
    int    err_cnt  = 0;
    int    meas_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n && meas_valid) begin
            mq.push_back('{int'(period), int'(vmin), int'(vmax)});
            meas_cnt++;
        end
        if (rst_n && err_timeout) err_cnt++;
    end

    // Last published results expected from the model
    int exp_per = 0;
    int exp_mn  = 1023;
    int exp_mx  = 0;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic expect_meas(input string tag, input int budget,
                               input int e_per, input int e_mn, input int e_mx);
        meas_t m;
        int    n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (mq.size() > 0) break;
        end
        if (mq.size() == 0) begin
            check({tag, "_no_meas"}, 0, 1);
        end else begin
            m = mq.pop_front();
            check({tag, "_period"}, m.per, e_per);
            check({tag, "_vmin"},   m.mn,  e_mn);
            check({tag, "_vmax"},   m.mx,  e_mx);
            exp_per = e_per;
            exp_mn  = e_mn;
            exp_mx  = e_mx;
        end
    endtask

    task automatic set_square(input int h, input int lo, input int hi, input bit blk);
        mode = 1; half = h; lo_lvl = lo; hi_lvl = hi; blank_en = blk;
        cycles(4 * h);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) check({tag, "_idle_timeout"}, 0, 1);
        cycles(3);
        mq.delete();
    endtask

    initial begin
        int e0, m0, n, h, lo, hi;
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
        cycles(3);
        @(negedge clk);
        check("rst_period", period, 0);
        check("rst_vmin", vmin, 1023);
        check("rst_vmax", vmax, 0);
        check("rst_busy", busy, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_err", err_timeout, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1. Square 0/1023, half-period 50, then randomized squares
        set_square(50, 0, 1023, 1'b0);
        e0 = err_cnt;
        pulse_start();
        expect_meas("sq_spec", 1500, 100, 0, 1023);
        check("sq_spec_no_err", err_cnt - e0, 0);
        for (int i = 0; i < 4; i++) begin
            h  = $urandom_range(20, 60);
            lo = $urandom_range(0, 496);
            hi = $urandom_range(528, 1023);
            set_square(h, lo, hi, 1'b0);
            pulse_start();
            expect_meas("sq_rand", 1500, 2 * h, lo, hi);
        end

        // 4. Blanked glitch in the low phase of every period
        set_square(50, 0, 1023, 1'b1);
        pulse_start();
        expect_meas("blank_spec", 1500, 100, 0, 1023);
        for (int i = 0; i < 2; i++) begin
            h  = $urandom_range(20, 60);
            lo = $urandom_range(0, 496);
            hi = $urandom_range(528, 1000);
            set_square(h, lo, hi, 1'b1);
            pulse_start();
            expect_meas("blank_rand", 1500, 2 * h, lo, hi);
        end
        blank_en = 1'b0;

        // 2. Saw ramps with continuous re-arm
        for (int i = 0; i < 3; i++) begin
            int st;
            st   = (i == 0) ? 8 : int'($urandom_range(8, 16));
            mode = 2; step = st; rlen = 1023 / st + 1;
            cycles(3 * rlen);
            continuous = 1'b1;
            pulse_start();
            for (int k = 0; k < 3; k++)
                expect_meas("ramp", 1500, rlen, 0, (rlen - 1) * st);
            continuous = 1'b0;
            wait_idle("ramp");
        end

        // 3. Constant mid-scale: no crossing, timeout after TMO cycles
        mode = 0; const_lvl = 512;
        cycles(5);
        e0 = err_cnt; m0 = meas_cnt;
        pulse_start();
        for (n = 1; n <= TMO + 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (err_timeout) break;
        end
        check("tmo_latency", n, TMO);
        @(negedge clk);
        check("tmo_busy_after", busy, 0);
        check("tmo_pulse_width", err_timeout, 0);
        check("tmo_err_count", err_cnt - e0, 1);
        check("tmo_no_meas", meas_cnt - m0, 0);
        check("tmo_keep_period", period, exp_per);
        check("tmo_keep_vmin", vmin, exp_mn);
        check("tmo_keep_vmax", vmax, exp_mx);

        // 5. Second start while busy is ignored
        lo = $urandom_range(0, 496);
        hi = $urandom_range(528, 1023);
        set_square(50, lo, hi, 1'b0);
        m0 = meas_cnt;
        pulse_start();
        cycles(30);
        pulse_start();
        expect_meas("dbl_start", 1500, 100, lo, hi);
        cycles(800);
        check("dbl_start_count", meas_cnt - m0, 1);

        // 6. Reset mid-MEASURE discards everything
        pulse_start();
        cycles(350);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mrst_period", period, 0);
        check("mrst_vmin", vmin, 1023);
        check("mrst_vmax", vmax, 0);
        check("mrst_busy", busy, 0);
        m0 = meas_cnt;
        cycles(800);
        check("mrst_no_meas", meas_cnt - m0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ddfs_wave_monitor
